// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// Define ARB_FAIR_EN to build the fetch-fairness counter; without it data wins every tie.
module mem_port_arbiter #(
    parameter int FAIR_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_adr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_adr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        if_stall,
    output logic        d_stall
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IF_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_adr_q, m_adr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic fair_force;
    logic if_win;
    logic grant_if;
    logic grant_d;

    // Priority is decided on the raw requests; the retiring requester is then
    // blocked from a re-grant rather than handing the slot to the other side.
    assign if_win   = if_req & (~d_req | fair_force);
    assign grant_if = (state_q == IDLE) & if_win & ~if_ack_q;
    assign grant_d  = (state_q == IDLE) & d_req & ~if_win & ~d_ack_q;

`ifdef ARB_FAIR_EN
    localparam logic [1:0] FAIR_MAX_C = 2'(FAIR_MAX);

    logic [1:0] fair_q, fair_d;

    assign fair_force = (fair_q == FAIR_MAX_C);

    always_comb begin
        fair_d = fair_q;
        if (grant_if)
            fair_d = 2'd0;
        else if (grant_d && if_req && (fair_q != 2'd3))
            fair_d = fair_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fair_q <= 2'd0;
        else     fair_q <= fair_d;
    end
`else
    logic unused_fair_max;
    assign unused_fair_max = ^FAIR_MAX;
    assign fair_force      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        m_we_d     = m_we_q;
        m_adr_d    = m_adr_q;
        m_wdata_d  = m_wdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d   = IF_BUSY;
                    m_adr_d   = if_adr;
                    m_we_d    = 1'b0;
                    m_wdata_d = 32'd0;
                end else if (grant_d) begin
                    state_d   = D_BUSY;
                    m_adr_d   = d_adr;
                    m_we_d    = d_we;
                    m_wdata_d = d_wdata;
                end
            end
            IF_BUSY: begin
                if (m_ack) begin
                    state_d    = IDLE;
                    if_ack_d   = 1'b1;
                    if_rdata_d = m_rdata;
                end
            end
            D_BUSY: begin
                if (m_ack) begin
                    state_d = IDLE;
                    d_ack_d = 1'b1;
                    if (!m_we_q) d_rdata_d = m_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            m_we_q     <= 1'b0;
            m_adr_q    <= 32'd0;
            m_wdata_q  <= 32'd0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            m_we_q     <= m_we_d;
            m_adr_q    <= m_adr_d;
            m_wdata_q  <= m_wdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign m_req    = (state_q != IDLE);
    assign m_we     = m_we_q;
    assign m_adr    = m_adr_q;
    assign m_wdata  = m_wdata_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_stall = if_req & ~if_ack_q;
    assign d_stall  = d_req & ~d_ack_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter FAIR_MAX, default 2: max consecutive data grants while a fetch is pending.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch request; held with if_adr stable until if_ack.
REQ-005 if_adr  input  32  fetch word address.
REQ-006 if_rdata  output  32  registered fetch data, valid while if_ack=1.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data request from MEM stage; held with d_we, d_adr and d_wdata stable until d_ack.
REQ-009 d_we  input  1  1=store (sw), 0=load (lw).
REQ-010 d_adr  input  32  data address (ALU result).
REQ-011 d_wdata  input  32  store data (busB).
REQ-012 d_rdata  output  32  registered load data, valid while d_ack=1.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 m_req, m_we  output  1 each  shared memory port request and write enable.
REQ-015 m_adr, m_wdata  output  32 each  shared memory port address and write data.
REQ-016 m_rdata  input  32  memory read data, sampled when m_ack=1.
REQ-017 m_ack  input  1  memory completion; variable latency, may assert in the first m_req cycle.
REQ-018 if_stall, d_stall  output  1 each  combinational: if_req&~if_ack and d_req&~d_ack.

Function
REQ-019 FSM states IDLE, IF_BUSY, D_BUSY; one transaction outstanding at most.
REQ-020 IDLE: d_req only -> D_BUSY; if_req only -> IF_BUSY; both -> D_BUSY unless fairness forces IF_BUSY (REQ-027); neither -> IDLE.
REQ-021 Grant edge latches the winner's address, we and wdata into the port registers; the fetch path forces m_we=0.
REQ-022 m_req=1 in every BUSY cycle and 0 in IDLE; m_adr, m_we and m_wdata stay constant for the whole transaction.
REQ-023 BUSY with m_ack=1 -> IDLE at the next edge; that same edge sets the owner's ack to 1 for exactly one cycle and loads m_rdata into its rdata register; a store does not update d_rdata.
REQ-024 Latency with zero-wait memory: request at cycle 0, m_req at cycle 1, ack at cycle 2; each added memory wait cycle adds one cycle.
REQ-025 IDLE ignores any requester whose ack is 1 in that cycle, so the retiring request is not re-granted.
REQ-026 m_ack in IDLE is ignored; requests arriving while BUSY wait and are not lost.
REQ-027 Fairness counter, 2 bits, saturating:
- increments on each D grant made while if_req=1;
- clears on any IF grant;
- when it equals FAIR_MAX and both requests are pending, IF wins.
REQ-028 rdata registers hold their value between acks.

Reset
REQ-029 rst=1 immediately forces the following, independent of clk: state IDLE, m_req=0, m_we=0, m_adr=0, m_wdata=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, fairness counter 0.
REQ-030 Reset during BUSY abandons the transaction with no ack; a late m_ack after reset release is ignored per REQ-026.

Configuration
REQ-031 Macro ARB_FAIR_EN defined: the fairness counter and REQ-027 are present.
REQ-032 Macro ARB_FAIR_EN undefined: no counter is built and data wins every tie (strict priority); all other behaviour is identical.

Verification
REQ-033 Single load, zero-wait memory: d_req=1, d_we=0, d_adr=0x10, m_rdata=0xDEADBEEF -> m_req at cycle 1 with m_adr=0x10, d_ack=1 and d_rdata=0xDEADBEEF at cycle 2, then IDLE.
REQ-034 Fetch with 3 wait cycles: if_req=1, if_adr=0x40 -> m_req high for 4 cycles with m_we=0, single if_ack pulse, if_stall=1 until the ack cycle.
REQ-035 Tie with ARB_FAIR_EN and FAIR_MAX=2: if_req and d_req held continuously, d_req re-raised after each ack -> grant order D, D, IF, D, D, IF.
REQ-036 Same stimulus as REQ-035 without ARB_FAIR_EN -> IF is never granted while d_req is pending.
REQ-037 Store: d_we=1, d_wdata=0x12345678 -> m_we=1, m_wdata=0x12345678, d_ack pulses, d_rdata unchanged.
REQ-038 rst asserted in the 2nd D_BUSY cycle -> m_req=0 at once, no d_ack, m_ack one cycle after release ignored, next if_req served normally.
